// File: rtl/sram_xbar_n.sv
// One-master / N-slave SRAM-port crossbar with base/mask decode, 1-cycle response steering
// and unmapped-access error capture. Define SRAM_XBAR_PERF_CNT_EN to add per-slave access counters.
module sram_xbar_n #(
  parameter int N_SLAVE   = 4,
  parameter int LEN_ADDR  = 64,
  parameter int LEN_DATA  = 64,
  parameter logic [N_SLAVE*LEN_ADDR-1:0] SLAVE_BASE = {N_SLAVE{LEN_ADDR'(64'h0)}},
  parameter logic [N_SLAVE*LEN_ADDR-1:0] SLAVE_MASK = {N_SLAVE{LEN_ADDR'(64'hF000_0000)}},
  parameter logic [LEN_DATA-1:0]         ERR_DATA   = LEN_DATA'(64'hDEAD_BEEF_DEAD_BEEF),
  parameter int ERR_CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [LEN_ADDR-1:0]            m_addra,
  input  logic [LEN_DATA-1:0]            m_dina,
  output logic [LEN_DATA-1:0]            m_douta,
  input  logic                           m_ena,
  input  logic [LEN_DATA/8-1:0]          m_wea,
  output logic [N_SLAVE*LEN_ADDR-1:0]    s_addra,
  output logic [N_SLAVE*LEN_DATA-1:0]    s_dina,
  input  logic [N_SLAVE*LEN_DATA-1:0]    s_douta,
  output logic [N_SLAVE-1:0]             s_ena,
  output logic [N_SLAVE*LEN_DATA/8-1:0]  s_wea,
  input  logic                           err_clr,
  output logic                           err_valid,
  output logic                           err_is_write,
  output logic [LEN_ADDR-1:0]            err_addr,
  output logic [ERR_CNT_W-1:0]           err_count
`ifdef SRAM_XBAR_PERF_CNT_EN
  ,
  output logic [N_SLAVE*32-1:0]          perf_cnt
`endif
);

  localparam int SEL_W = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
  localparam int WE_W  = LEN_DATA / 8;

  logic [SEL_W-1:0] sel;
  logic             miss;
  logic [SEL_W-1:0] rsp_sel;
  logic             rsp_err;
  logic             miss_acc;

  // Scanning from the top down lets the lowest matching index win on overlap.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel  = '0;
    miss = 1'b1;
    for (int i = N_SLAVE - 1; i >= 0; i--) begin
      if ((m_addra & SLAVE_MASK[i*LEN_ADDR +: LEN_ADDR]) == SLAVE_BASE[i*LEN_ADDR +: LEN_ADDR]) begin
        sel  = SEL_W'(i);
        miss = 1'b0;
      end
    end
  end

  assign miss_acc = m_ena & miss;

  for (genvar g = 0; g < N_SLAVE; g++) begin : g_slave
    assign s_ena[g]                         = m_ena & ~miss & (sel == SEL_W'(g));
    assign s_wea[g*WE_W +: WE_W]            = s_ena[g] ? m_wea : '0;
    assign s_addra[g*LEN_ADDR +: LEN_ADDR]  = m_addra & ~SLAVE_MASK[g*LEN_ADDR +: LEN_ADDR];
    assign s_dina[g*LEN_DATA +: LEN_DATA]   = m_dina;
  end

  // Response steering is registered to line up with the slaves' 1-cycle read latency.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_sel <= '0;
      rsp_err <= 1'b0;
    end else if (m_ena) begin
      rsp_sel <= sel;
      rsp_err <= miss;
    end
  end

  assign m_douta = rsp_err ? ERR_DATA : s_douta[int'(rsp_sel)*LEN_DATA +: LEN_DATA];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_valid    <= 1'b0;
      err_is_write <= 1'b0;
      err_addr     <= '0;
    end else begin
      err_valid <= miss_acc;
      if (miss_acc) begin
        err_addr     <= m_addra;
        err_is_write <= |m_wea;
      end
    end
  end

  // A clear coinciding with a miss still records that miss.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= miss_acc ? ERR_CNT_W'(1) : '0;
    end else if (miss_acc && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

`ifdef SRAM_XBAR_PERF_CNT_EN
  for (genvar g = 0; g < N_SLAVE; g++) begin : g_perf
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        perf_cnt[g*32 +: 32] <= '0;
      end else if (err_clr) begin
        perf_cnt[g*32 +: 32] <= '0;
      end else if (s_ena[g]) begin
        perf_cnt[g*32 +: 32] <= perf_cnt[g*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_xbar_n.sv
// Directed bench for sram_xbar_n: 2 slaves at 0x0 and 0x6000_0000 (mask F000_0000),
// 2-bit error counter so saturation is reachable.
module tb_sram_xbar_n;

  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam logic [63:0] ERR = 64'hDEAD_BEEF_DEAD_BEEF;

  logic              clk = 1'b0;
  logic              resetn;
  logic [AW-1:0]     m_addra;
  logic [DW-1:0]     m_dina;
  logic [DW-1:0]     m_douta;
  logic              m_ena;
  logic [DW/8-1:0]   m_wea;
  logic [N*AW-1:0]   s_addra;
  logic [N*DW-1:0]   s_dina;
  logic [N*DW-1:0]   s_douta;
  logic [N-1:0]      s_ena;
  logic [N*DW/8-1:0] s_wea;
  logic              err_clr;
  logic              err_valid;
  logic              err_is_write;
  logic [AW-1:0]     err_addr;
  logic [1:0]        err_count;
`ifdef SRAM_XBAR_PERF_CNT_EN
  logic [N*32-1:0]   perf_cnt;
`endif

  int tests = 0;
  int fails = 0;

  sram_xbar_n #(
    .N_SLAVE    (N),
    .LEN_ADDR   (AW),
    .LEN_DATA   (DW),
    .SLAVE_BASE ({64'h6000_0000, 64'h0}),
    .SLAVE_MASK ({64'hF000_0000, 64'hF000_0000}),
    .ERR_DATA   (ERR),
    .ERR_CNT_W  (2)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .m_addra      (m_addra),
    .m_dina       (m_dina),
    .m_douta      (m_douta),
    .m_ena        (m_ena),
    .m_wea        (m_wea),
    .s_addra      (s_addra),
    .s_dina       (s_dina),
    .s_douta      (s_douta),
    .s_ena        (s_ena),
    .s_wea        (s_wea),
    .err_clr      (err_clr),
    .err_valid    (err_valid),
    .err_is_write (err_is_write),
    .err_addr     (err_addr),
    .err_count    (err_count)
`ifdef SRAM_XBAR_PERF_CNT_EN
    ,
    .perf_cnt     (perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return #1 after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic [63:0] addr, input logic [7:0] we, input logic [63:0] data);
    m_addra = addr;
    m_wea   = we;
    m_dina  = data;
    m_ena   = 1'b1;
  endtask

  initial begin
    resetn  = 1'b0;
    m_addra = '0;
    m_dina  = '0;
    m_ena   = 1'b0;
    m_wea   = '0;
    err_clr = 1'b0;
    s_douta = {64'hBBBB, 64'hAAAA};

    #2;
    check("rst_err_valid", 64'(err_valid), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_err_addr", err_addr, 64'd0);
    check("rst_err_is_write", 64'(err_is_write), 64'd0);
    check("rst_douta_slot0", m_douta, 64'hAAAA);
    #1 resetn = 1'b1;
    step();

    // Single read to slave 1 with offset forwarding.
    access(64'h6000_0010, 8'h00, 64'h0);
    #1;
    check("rd1_s_ena", 64'(s_ena), 64'h2);
    check("rd1_s_addra1", s_addra[AW +: AW], 64'h10);
    check("rd1_s_wea", 64'(s_wea), 64'h0);
    step();
    m_ena = 1'b0;
    check("rd1_douta", m_douta, 64'hBBBB);
    step();
    check("idle_hold_slave1", m_douta, 64'hBBBB);
    s_douta[DW +: DW] = 64'hCCCC;
    #1;
    check("idle_track_slave1", m_douta, 64'hCCCC);
    s_douta[DW +: DW] = 64'hBBBB;

    // Back-to-back reads slave0 then slave1, no bubble.
    access(64'h0000_0100, 8'h00, 64'h0);
    #1;
    check("b2b_s_ena0", 64'(s_ena), 64'h1);
    step();
    access(64'h6000_0200, 8'h00, 64'h0);
    check("b2b_douta0", m_douta, 64'hAAAA);
    step();
    m_ena = 1'b0;
    check("b2b_douta1", m_douta, 64'hBBBB);

    // Partial write to slave 0: enables only on slot 0, data broadcast.
    access(64'h0000_0040, 8'h0F, 64'h1122_3344_5566_7788);
    #1;
    check("wr_s_wea", 64'(s_wea), 64'h000F);
    check("wr_s_dina1", s_dina[DW +: DW], 64'h1122_3344_5566_7788);
    check("wr_s_addra0", s_addra[0 +: AW], 64'h40);
    step();
    m_ena = 1'b0;

    // Unmapped write: dropped, error captured.
    access(64'h7000_0000, 8'hFF, 64'h55);
    #1;
    check("uw_s_ena", 64'(s_ena), 64'h0);
    check("uw_s_wea", 64'(s_wea), 64'h0);
    step();
    m_ena = 1'b0;
    check("uw_err_valid", 64'(err_valid), 64'd1);
    check("uw_err_is_write", 64'(err_is_write), 64'd1);
    check("uw_err_addr", err_addr, 64'h7000_0000);
    check("uw_err_count", 64'(err_count), 64'd1);
    check("uw_douta", m_douta, ERR);
    step();
    check("uw_pulse_end", 64'(err_valid), 64'd0);
    check("uw_addr_sticky", err_addr, 64'h7000_0000);

    // Unmapped read: ERR_DATA held across idle cycles.
    access(64'h8000_0004, 8'h00, 64'h0);
    step();
    m_ena = 1'b0;
    check("ur_douta", m_douta, ERR);
    check("ur_err_is_write", 64'(err_is_write), 64'd0);
    check("ur_err_addr", err_addr, 64'h8000_0004);
    check("ur_err_count", 64'(err_count), 64'd2);
    step(); step(); step();
    check("ur_douta_held", m_douta, ERR);

    // Three more misses (five total) saturate the 2-bit counter.
    access(64'h9000_0000, 8'h00, 64'h0);
    step(); step(); step();
    m_ena = 1'b0;
    check("sat_count", 64'(err_count), 64'd3);

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_alone", 64'(err_count), 64'd0);
    err_clr = 1'b1;
    access(64'hA000_0000, 8'h00, 64'h0);
    step();
    err_clr = 1'b0;
    m_ena   = 1'b0;
    check("clr_with_miss", 64'(err_count), 64'd1);
    check("clr_miss_valid", 64'(err_valid), 64'd1);

    // Asynchronous reset mid-stream, observed before the next edge.
    #2 resetn = 1'b0;
    #1;
    check("arst_err_valid", 64'(err_valid), 64'd0);
    check("arst_err_count", 64'(err_count), 64'd0);
    check("arst_err_addr", err_addr, 64'd0);
    check("arst_err_is_write", 64'(err_is_write), 64'd0);
    check("arst_douta", m_douta, 64'hAAAA);
    #2 resetn = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_xbar_n.md
Name: sram_xbar_n

Overview:
- Parametrised 1-master / N-slave SRAM-port crossbar; successor to the fixed 2-slave, single-compare crossbar.
- Sits between the pipeline data port and the data SRAM plus the memory-mapped peripherals (board IO, future timers/UART).
- Decodes slaves from per-slave base/mask tables, forwards address offsets, registers the response select to match the 1-cycle SRAM read latency.
- Returns an error pattern for unmapped accesses and keeps sticky error capture and an error counter.

Parameters:
- N_SLAVE, 4, number of slave ports (1..16).
- LEN_ADDR, 64, address width.
- LEN_DATA, 64, data width; must be a multiple of 8.
- SLAVE_BASE, {N_SLAVE{64'h0}}, packed N_SLAVE*LEN_ADDR base table; slot i at bits [i*LEN_ADDR +: LEN_ADDR].
- SLAVE_MASK, {N_SLAVE{64'hF000_0000}}, packed N_SLAVE*LEN_ADDR compare mask table.
- ERR_DATA, 64'hDEAD_BEEF_DEAD_BEEF, read data returned for unmapped reads.
- ERR_CNT_W, 16, error counter width.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- m_addra  input  LEN_ADDR  master byte address.
- m_dina  input  LEN_DATA  master write data.
- m_douta  output  LEN_DATA  master read data, valid the cycle after m_ena.
- m_ena  input  1  master access enable.
- m_wea  input  LEN_DATA/8  master byte write enables; 0 means read.
- s_addra  output  N_SLAVE*LEN_ADDR  per-slave offset address.
- s_dina  output  N_SLAVE*LEN_DATA  per-slave write data (broadcast).
- s_douta  input  N_SLAVE*LEN_DATA  per-slave read data.
- s_ena  output  N_SLAVE  per-slave enable.
- s_wea  output  N_SLAVE*LEN_DATA/8  per-slave byte write enables.
- err_clr  input  1  synchronous clear of err_count.
- err_valid  output  1  one-cycle pulse per unmapped access.
- err_is_write  output  1  captured: the last error was a write.
- err_addr  output  LEN_ADDR  captured address of the last error.
- err_count  output  ERR_CNT_W  saturating unmapped-access count.

Behaviour:
- Decode (combinational):
  - hit[i] = ((m_addra & MASK[i]) == BASE[i]).
  - sel = lowest i with hit[i]; overlapping regions are resolved by lowest index.
  - miss = no hit.
- Request path (combinational, zero latency):
  - s_ena[i] = m_ena & !miss & (sel==i).
  - s_wea[i] = s_ena[i] ? m_wea : 0.
  - s_addra slot i = m_addra & ~MASK[i].
  - s_dina slot i = m_dina.
  - On a miss, no s_ena is asserted and the write is dropped.
- Response state (regs rsp_sel, rsp_err):
  - On a clk edge with m_ena=1: rsp_sel <= sel and rsp_err <= miss.
  - With m_ena=0 both hold.
  - m_douta = rsp_err ? ERR_DATA : s_douta[rsp_sel].
  - Read latency is 1 cycle. With no new access, m_douta keeps tracking the last-selected slave, which holds its douta.
  - Back-to-back accesses to different slaves: each response returns in order, 1 cycle later, with no bubble.
- Error capture, on a clk edge with m_ena & miss:
  - err_valid <= 1, otherwise 0. The pulse appears in the same cycle as the ERR_DATA response.
  - err_addr <= m_addra.
  - err_is_write <= |m_wea.
  - err_addr and err_is_write are sticky until the next error.
- err_count:
  - Increments on each miss access and saturates at all-ones.
  - err_clr alone: count becomes 0.
  - err_clr together with a miss in the same cycle: count becomes 1.
- Reset (resetn low, asynchronous): rsp_sel=0, rsp_err=0, err_valid=0, err_is_write=0, err_addr=0, err_count=0. m_douta then shows s_douta slot 0.
- Reset mid-access: the in-flight response is discarded and the registers return to reset values immediately. Slave-side state is the slave's concern.
- N_SLAVE=1: sel is constant 0; every non-hit is an error.

Optional Feature:
- Macro: SRAM_XBAR_PERF_CNT_EN.
- When defined:
  - Adds output perf_cnt, N_SLAVE*32 bits.
  - One 32-bit wrapping counter per slave, incremented on each clk edge with s_ena[i]=1.
  - Counters are reset to 0 by resetn and by err_clr.
- When undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- N_SLAVE=2, BASE={0x6000_0000, 0x0}, MASK=F000_0000; read 0x6000_0010 -> s_ena=2'b10, s_addra[1]=0x10, m_douta=s_douta[1] next cycle.
- Back-to-back reads slave0 then slave1, slave douta=0xAAAA / 0xBBBB -> m_douta = 0xAAAA at N+1, 0xBBBB at N+2.
- Write 0x7000_0000 with wea=0xFF (unmapped) -> no s_ena; next cycle err_valid=1, err_is_write=1, err_addr=0x7000_0000, err_count=1.
- Read unmapped -> m_douta=ERR_DATA; then m_ena=0 for 3 cycles -> m_douta stays ERR_DATA.
- ERR_CNT_W=2: 5 misses -> err_count=3; err_clr together with a miss -> err_count=1.
- Assert resetn=0 mid-stream after a miss -> err_* = 0 and rsp_err = 0 without waiting for a clk edge.
